// File: rtl/wavefront_deskew.sv
// wavefront_deskew
// Takes the staggered rows leaving a systolic array and lines them up again.
// Channel i arrives i cycles after channel 0. It is delayed by N-1-i cycles, so
// every channel of a row reaches the alignment point in the same cycle. A
// registered output stage then either emits the row, ignores an empty slot, or
// drops a partial row and raises a sticky skew flag.
module wavefront_deskew #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din [0:N-1],
  input  logic [N-1:0]          din_valid,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dout [0:N-1],
  output logic                  dout_valid,
  output logic                  skew_err,
  output logic [CNT_WIDTH-1:0]  row_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  // Data and valid of every channel as seen at the alignment point.
  logic [DATA_WIDTH-1:0] al_data [0:N-1];
  logic [N-1:0]          al_valid;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_ch
      localparam int D = N - 1 - g;
      if (D == 0) begin : g_direct
        // The last channel is already aligned and goes straight to the output stage.
        assign al_data[g]  = din[g];
        assign al_valid[g] = din_valid[g];
      end else begin : g_dly
        logic [DATA_WIDTH-1:0] data_q [0:D-1];
        logic [D-1:0]          valid_q;

        // Free-running shift line. Invalid data words shift along with the rest,
        // and reset clears valids so no pre-reset row can come out later.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int k = 0; k < D; k++) data_q[k] <= '0;
            valid_q <= '0;
          end else begin
            data_q[0]  <= din[g];
            valid_q[0] <= din_valid[g];
            for (int k = 1; k < D; k++) begin
              data_q[k]  <= data_q[k-1];
              valid_q[k] <= valid_q[k-1];
            end
          end
        end

        assign al_data[g]  = data_q[D-1];
        assign al_valid[g] = valid_q[D-1];
      end
    end
  endgenerate

  logic [DATA_WIDTH-1:0] dout_q [0:N-1];
  logic [DATA_WIDTH-1:0] dout_d [0:N-1];
  logic                  dout_valid_q, dout_valid_d;
  logic                  skew_err_q, skew_err_d;
  logic [CNT_WIDTH-1:0]  row_count_q, row_count_d;
  logic                  av_all, av_none;

  // Classify the aligned valid vector: full row, empty slot, or partial row.
  // A partial row outranks err_clr, so a clear never hides a fresh mismatch.
  always_comb begin
    av_all       = &al_valid;
    av_none      = ~|al_valid;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    row_count_d  = row_count_q;
    skew_err_d   = skew_err_q;
    if (av_all) begin
      dout_d       = al_data;
      dout_valid_d = 1'b1;
      row_count_d  = row_count_q + CNT_ONE;
    end
    if (!av_all && !av_none) begin
      skew_err_d = 1'b1;
    end else if (err_clr) begin
      skew_err_d = 1'b0;
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) dout_q[k] <= '0;
      dout_valid_q <= 1'b0;
      skew_err_q   <= 1'b0;
      row_count_q  <= '0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      skew_err_q   <= skew_err_d;
      row_count_q  <= row_count_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign skew_err   = skew_err_q;
  assign row_count  = row_count_q;

endmodule
